// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter for one shared memory bus.
// Define ARB_TIMEOUT_EN to abort busy transactions after TIMEOUT_CYCLES with err.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we0,
    input  logic              we1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              grant_sel,
    output logic              bus_valid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d;
    logic              valid_q, valid_d, we_q, we_d, gsel_q, gsel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              elig0, elig1, pick0, pick1, timeout;

    // A requester seeing its ack this cycle is not re-granted until next cycle.
    assign elig0 = req0 & ~ack0_q;
    assign elig1 = req1 & ~ack1_q;
    assign pick0 = elig0 & (~elig1 | last_q);
    assign pick1 = elig1 & (~elig0 | ~last_q);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt_d   = (state_q == IDLE) ? '0 : cnt_q + CW'(1);
    assign timeout = (state_q != IDLE) & ~bus_ready & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = 1'b0;
        valid_d = valid_q;
        we_d    = we_q;
        gsel_d  = gsel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (state_q == IDLE) begin
            if (pick0 | pick1) begin
                state_d = pick0 ? BUSY0 : BUSY1;
                valid_d = 1'b1;
                gsel_d  = pick0;
                addr_d  = pick0 ? addr0 : addr1;
                wdata_d = pick0 ? wdata0 : wdata1;
                we_d    = pick0 ? we0 : we1;
            end
        end else if (bus_ready | timeout) begin
            state_d = IDLE;
            last_d  = (state_q == BUSY1);
            ack0_d  = (state_q == BUSY0);
            ack1_d  = (state_q == BUSY1);
            err_d   = timeout;
            rdata_d = timeout ? '0 : bus_rdata;
            valid_d = 1'b0;
            we_d    = 1'b0;
            gsel_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            gsel_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            gsel_q  <= gsel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign grant_sel = gsel_q;
    assign bus_valid = valid_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = we_q;
endmodule
